// File: rtl/enc_pkg.sv
// enc_pkg: shared constants and types for the 4-to-2 streaming encoder.
//   LINES  - number of one-hot select lines entering the encoder
//   CODE_W - width of the binary index produced
//   line_t - line vector type, bit k set means line k is active
//   code_t - encoded index type
package enc_pkg;

    localparam int LINES  = 4;
    localparam int CODE_W = 2;

    typedef logic [LINES-1:0]  line_t;
    typedef logic [CODE_W-1:0] code_t;

endpackage

// File: rtl/enc_4_2_core.sv
// enc_4_2_core: combinational 4-to-2 encoder.
// Build option: ENC_PRIORITY_EN
//   defined   - multi-hot input is legal, y is the index of the highest set
//               line; only the all-zero vector is flagged as an error.
//   undefined - strict one-hot; any vector without exactly one set line is
//               flagged as an error and encodes to 0.
// Ports:
//   i   in  line vector
//   y   out encoded index
//   err out input vector is illegal
module enc_4_2_core
    import enc_pkg::*;
(
    input  line_t i,
    output code_t y,
    output logic  err
);

    always_comb begin
        y   = '0;
        err = 1'b0;
`ifdef ENC_PRIORITY_EN
        if (i[3]) begin
            y = 2'd3;
        end else if (i[2]) begin
            y = 2'd2;
        end else if (i[1]) begin
            y = 2'd1;
        end else if (i[0]) begin
            y = 2'd0;
        end else begin
            err = 1'b1;
        end
`else
        case (i)
            4'b0001: y = 2'd0;
            4'b0010: y = 2'd1;
            4'b0100: y = 2'd2;
            4'b1000: y = 2'd3;
            default: err = 1'b1;
        endcase
`endif
    end

endmodule

// File: rtl/encoder_4_2_stream.sv
// encoder_4_2_stream: registered 4-to-2 encoder with valid/ready handshake
// and a saturating count of illegal words accepted.
// Build option: ENC_PRIORITY_EN (selects priority vs strict one-hot encoding,
// see enc_4_2_core).
// Parameters:
//   CNT_W - width of the saturating error counter
// Ports:
//   clk       in  rising-edge clock
//   rst       in  asynchronous active-high reset
//   in_valid  in  input word valid
//   in_ready  out block can accept a word this cycle
//   i         in  line vector
//   out_valid out registered output valid
//   out_ready in  downstream accepts output
//   y         out encoded index
//   out_err   out the word currently held was illegal
//   err_cnt   out number of illegal words accepted, saturating
module encoder_4_2_stream
    import enc_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       y,
    output logic             out_err,
    output logic [CNT_W-1:0] err_cnt
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        if (&c) begin
            return c;
        end
        return c + CNT_W'(1);
    endfunction

    code_t            enc_y_p0;
    logic             enc_err_p0;
    logic             accept_p0;

    logic             vld_p1;
    code_t            y_p1;
    logic             err_p1;
    logic [CNT_W-1:0] cnt_p1;

    // ---- stage 0: combinational encode and handshake decision ----
    enc_4_2_core u_core (
        .i   (line_t'(i)),
        .y   (enc_y_p0),
        .err (enc_err_p0)
    );

    // Ready whenever the output slot is empty or being drained this cycle,
    // so a continuous stream flows without bubbles.
    assign in_ready  = !vld_p1 || out_ready;
    assign accept_p0 = in_valid && in_ready;

    // ---- stage 1: output register and error counter ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            y_p1   <= '0;
            err_p1 <= 1'b0;
            cnt_p1 <= '0;
        end else if (accept_p0) begin
            vld_p1 <= 1'b1;
            y_p1   <= enc_y_p0;
            err_p1 <= enc_err_p0;
            if (enc_err_p0) begin
                cnt_p1 <= sat_inc(cnt_p1);
            end
        end else if (out_ready) begin
            // Drained with nothing new: data holds its last value.
            vld_p1 <= 1'b0;
        end
    end

    assign out_valid = vld_p1;
    assign y         = y_p1;
    assign out_err   = err_p1;
    assign err_cnt   = cnt_p1;

endmodule
